// File: rtl/pll_dyn_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pll_dyn_cfg_ctrl
// Brief    : Shadowed dynamic-config writer and reset/lock sequencer for the PLL.
//            Optional macro PLL_CFG_READBACK_EN adds the cfg_rd/cfg_rdata port.
// Revision : 1.0 - initial release
// ============================================================================
module pll_dyn_cfg_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_STABLE  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_wr,
    input  logic [4:0]  cfg_addr,
    input  logic [12:0] cfg_wdata,
    input  logic        cfg_start,
`ifdef PLL_CFG_READBACK_EN
    input  logic        cfg_rd,
    output logic [12:0] cfg_rdata,
`endif
    input  logic        pll_lock,
    output logic        pll_rst,
    output logic [9:0]  dyn_idiv,
    output logic [9:0]  dyn_fdiv,
    output logic [9:0]  dyn_odiv0,
    output logic [9:0]  dyn_odiv1,
    output logic [9:0]  dyn_odiv2,
    output logic [9:0]  dyn_odiv3,
    output logic [9:0]  dyn_odiv4,
    output logic [9:0]  dyn_duty0,
    output logic [9:0]  dyn_duty1,
    output logic [9:0]  dyn_duty2,
    output logic [9:0]  dyn_duty3,
    output logic [9:0]  dyn_duty4,
    output logic [12:0] dyn_phase0,
    output logic [12:0] dyn_phase1,
    output logic [12:0] dyn_phase2,
    output logic [12:0] dyn_phase3,
    output logic [12:0] dyn_phase4,
    output logic        busy,
    output logic        locked,
    output logic        done,
    output logic        err,
    output logic        lock_lost
);

    localparam int c_RW = $clog2(RST_CYCLES + 1);
    localparam int c_TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int c_SW = $clog2(LOCK_STABLE + 1);
    localparam logic [c_RW-1:0] c_RST_LAST = c_RW'(RST_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TO_LAST  = c_TW'(LOCK_TIMEOUT - 1);
    localparam logic [c_TW-1:0] c_TO_MAX   = c_TW'(LOCK_TIMEOUT);
    localparam logic [c_SW-1:0] c_ST_LAST  = c_SW'(LOCK_STABLE - 1);
    localparam logic [c_SW-1:0] c_ST_MAX   = c_SW'(LOCK_STABLE);
    localparam logic [12:0]     c_PHASE_RST = 13'd16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_RST    = 3'd2,
        S_WAIT   = 3'd3,
        S_STABLE = 3'd4,
        S_LOCKED = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    // Index 0 idiv, 1 fdiv, 2..6 odiv, 7..11 duty; phases live in the 13-bit bank.
    function automatic logic [9:0] f_rst10(input int idx);
        case (idx)
            0:       f_rst10 = 10'd2;
            1:       f_rst10 = 10'd32;
            default: f_rst10 = 10'd100;
        endcase
    endfunction

    state_t            r_state;
    logic [c_RW-1:0]   r_rst_cnt;
    logic [c_TW-1:0]   r_to_cnt;
    logic [c_SW-1:0]   r_st_cnt;
    logic              r_lk_meta;
    logic              r_lk_s;
    logic [9:0]        r_sh10  [0:11];
    logic [12:0]       r_sh13  [0:4];
    logic [9:0]        r_dyn10 [0:11];
    logic [12:0]       r_dyn13 [0:4];

    logic              w_timeout;
    logic [c_TW-1:0]   w_to_inc;
    logic [c_SW-1:0]   w_st_inc;

    assign w_timeout = (r_to_cnt >= c_TO_LAST);
    assign w_to_inc  = (r_to_cnt == c_TO_MAX) ? r_to_cnt : r_to_cnt + 1'b1;
    assign w_st_inc  = (r_st_cnt == c_ST_MAX) ? r_st_cnt : r_st_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lk_meta <= 1'b0;
            r_lk_s    <= 1'b0;
        end else begin
            r_lk_meta <= pll_lock;
            r_lk_s    <= r_lk_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_RST;
            r_rst_cnt <= '0;
            r_to_cnt  <= '0;
            r_st_cnt  <= '0;
            pll_rst   <= 1'b1;
            busy      <= 1'b1;
            locked    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            lock_lost <= 1'b0;
            for (int i = 0; i < 12; i++) begin
                r_sh10[i]  <= f_rst10(i);
                r_dyn10[i] <= f_rst10(i);
            end
            for (int j = 0; j < 5; j++) begin
                r_sh13[j]  <= c_PHASE_RST;
                r_dyn13[j] <= c_PHASE_RST;
            end
        end else begin
            done      <= 1'b0;
            lock_lost <= 1'b0;

            if (cfg_wr) begin
                for (int i = 0; i < 12; i++)
                    if (cfg_addr == 5'(i)) r_sh10[i] <= cfg_wdata[9:0];
                for (int j = 0; j < 5; j++)
                    if (cfg_addr == 5'(j + 12)) r_sh13[j] <= cfg_wdata;
            end

            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_state <= S_APPLY;
                        busy    <= 1'b1;
                    end
                end
                S_APPLY: begin
                    for (int i = 0; i < 12; i++) r_dyn10[i] <= r_sh10[i];
                    for (int j = 0; j < 5; j++)  r_dyn13[j] <= r_sh13[j];
                    r_state   <= S_RST;
                    r_rst_cnt <= '0;
                    pll_rst   <= 1'b1;
                end
                S_RST: begin
                    if (r_rst_cnt == c_RST_LAST) begin
                        r_state  <= S_WAIT;
                        pll_rst  <= 1'b0;
                        r_to_cnt <= '0;
                        r_st_cnt <= '0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                S_WAIT, S_STABLE: begin
                    // Timeout outranks a stable count completing on the same edge.
                    if (w_timeout) begin
                        r_state <= S_ERR;
                        err     <= 1'b1;
                        pll_rst <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        r_to_cnt <= w_to_inc;
                        if (!r_lk_s) begin
                            r_state  <= S_WAIT;
                            r_st_cnt <= '0;
                        end else if (r_state == S_WAIT) begin
                            r_state  <= S_STABLE;
                            r_st_cnt <= '0;
                        end else if (r_st_cnt == c_ST_LAST) begin
                            r_state <= S_LOCKED;
                            locked  <= 1'b1;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            r_st_cnt <= w_st_inc;
                        end
                    end
                end
                S_LOCKED: begin
                    if (!r_lk_s) begin
                        r_state   <= S_WAIT;
                        lock_lost <= 1'b1;
                        locked    <= 1'b0;
                        busy      <= 1'b1;
                        r_to_cnt  <= '0;
                        r_st_cnt  <= '0;
                    end else if (cfg_start) begin
                        r_state <= S_APPLY;
                        locked  <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                S_ERR: begin
                    if (cfg_start) begin
                        r_state <= S_APPLY;
                        err     <= 1'b0;
                        pll_rst <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_CFG_READBACK_EN
    logic [12:0] r_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (cfg_rd) begin
            r_rdata <= '0;
            for (int i = 0; i < 12; i++)
                if (cfg_addr == 5'(i)) r_rdata <= {3'b000, r_sh10[i]};
            for (int j = 0; j < 5; j++)
                if (cfg_addr == 5'(j + 12)) r_rdata <= r_sh13[j];
        end
    end

    assign cfg_rdata = r_rdata;
`endif

    assign dyn_idiv   = r_dyn10[0];
    assign dyn_fdiv   = r_dyn10[1];
    assign dyn_odiv0  = r_dyn10[2];
    assign dyn_odiv1  = r_dyn10[3];
    assign dyn_odiv2  = r_dyn10[4];
    assign dyn_odiv3  = r_dyn10[5];
    assign dyn_odiv4  = r_dyn10[6];
    assign dyn_duty0  = r_dyn10[7];
    assign dyn_duty1  = r_dyn10[8];
    assign dyn_duty2  = r_dyn10[9];
    assign dyn_duty3  = r_dyn10[10];
    assign dyn_duty4  = r_dyn10[11];
    assign dyn_phase0 = r_dyn13[0];
    assign dyn_phase1 = r_dyn13[1];
    assign dyn_phase2 = r_dyn13[2];
    assign dyn_phase3 = r_dyn13[3];
    assign dyn_phase4 = r_dyn13[4];

endmodule
`default_nettype wire

// File: tb/tb_pll_dyn_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_dyn_cfg_ctrl
// Brief    : Directed self-checking bench for pll_dyn_cfg_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_dyn_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr;
    logic [4:0]  cfg_addr;
    logic [12:0] cfg_wdata;
    logic        cfg_start;
    logic        pll_lock;
    logic        pll_rst;
    logic [9:0]  dyn_idiv, dyn_fdiv;
    logic [9:0]  dyn_odiv0, dyn_odiv1, dyn_odiv2, dyn_odiv3, dyn_odiv4;
    logic [9:0]  dyn_duty0, dyn_duty1, dyn_duty2, dyn_duty3, dyn_duty4;
    logic [12:0] dyn_phase0, dyn_phase1, dyn_phase2, dyn_phase3, dyn_phase4;
    logic        busy, locked, done, err, lock_lost;
`ifdef PLL_CFG_READBACK_EN
    logic        cfg_rd;
    logic [12:0] cfg_rdata;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pll_dyn_cfg_ctrl #(
        .RST_CYCLES  (16),
        .LOCK_TIMEOUT(1000),
        .LOCK_STABLE (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_wr    (cfg_wr),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_start (cfg_start),
`ifdef PLL_CFG_READBACK_EN
        .cfg_rd    (cfg_rd),
        .cfg_rdata (cfg_rdata),
`endif
        .pll_lock  (pll_lock),
        .pll_rst   (pll_rst),
        .dyn_idiv  (dyn_idiv),
        .dyn_fdiv  (dyn_fdiv),
        .dyn_odiv0 (dyn_odiv0),
        .dyn_odiv1 (dyn_odiv1),
        .dyn_odiv2 (dyn_odiv2),
        .dyn_odiv3 (dyn_odiv3),
        .dyn_odiv4 (dyn_odiv4),
        .dyn_duty0 (dyn_duty0),
        .dyn_duty1 (dyn_duty1),
        .dyn_duty2 (dyn_duty2),
        .dyn_duty3 (dyn_duty3),
        .dyn_duty4 (dyn_duty4),
        .dyn_phase0(dyn_phase0),
        .dyn_phase1(dyn_phase1),
        .dyn_phase2(dyn_phase2),
        .dyn_phase3(dyn_phase3),
        .dyn_phase4(dyn_phase4),
        .busy      (busy),
        .locked    (locked),
        .done      (done),
        .err       (err),
        .lock_lost (lock_lost)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic measure_rst(input bit poke_start, output int n);
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin
            n++;
            cfg_start = (poke_start && n == 3);
            tick();
        end
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (done !== 1'b1 && k < 3000);
    endtask

    task automatic wait_err(output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (err !== 1'b1 && k < 3000);
    endtask

    task automatic wr(input logic [4:0] a, input logic [12:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_wr = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, k, n_done;
        rst = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        cfg_start = 1'b0; pll_lock = 1'b0;
`ifdef PLL_CFG_READBACK_EN
        cfg_rd = 1'b0;
`endif
        repeat (3) tick();

        // Reset state
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_flags", {busy, locked, done, err, lock_lost}, 5'b10000);
        chk("rst_div", {dyn_idiv, dyn_fdiv}, {10'd2, 10'd32});
        chk("rst_odiv0_phase0", {dyn_odiv0, dyn_phase0}, {10'd100, 13'd16});
`ifdef PLL_CFG_READBACK_EN
        chk("rst_rdata", cfg_rdata, 0);
`endif

        // Initial lock sequence
        rst = 1'b0;
        measure_rst(1'b0, n);
        chk("init_rst_len", n, 16);
        repeat (200) tick();
        pll_lock = 1'b1;
        wait_done(k);
        chk("init_done_latency", k, 67);
        chk("init_locked_busy", {locked, busy}, 2'b10);
        chk("init_odiv0_phase0", {dyn_odiv0, dyn_phase0}, {10'd100, 13'd16});
        tick();
        chk("init_done_pulse", done, 0);

        // Reconfiguration; addr 20 must be ignored
        wr(5'd20, 13'h1FFF);
        for (int a = 2; a <= 11; a++) wr(5'(a), 13'd200);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("apply_not_yet", {dyn_odiv0, pll_rst, busy, locked}, {10'd100, 3'b010});
        pll_lock = 1'b0;
        tick();
        chk("reconf_odiv", {dyn_odiv0, dyn_odiv1, dyn_odiv2, dyn_odiv3, dyn_odiv4}, {5{10'd200}});
        chk("reconf_duty", {dyn_duty0, dyn_duty1, dyn_duty2, dyn_duty3, dyn_duty4}, {5{10'd200}});
        chk("reconf_phase", {dyn_phase0, dyn_phase1, dyn_phase2, dyn_phase3, dyn_phase4}, {5{13'd16}});
        chk("reconf_div_untouched", {dyn_idiv, dyn_fdiv}, {10'd2, 10'd32});
        measure_rst(1'b1, n);
        chk("reconf_rst_len_start_ignored", n, 16);
        repeat (50) tick();
        pll_lock = 1'b1;
        wait_done(k);
        chk("reconf_done", {done, locked}, 2'b11);

        // Write and start in the same cycle
        cfg_wr = 1'b1; cfg_addr = 5'd0; cfg_wdata = 13'd5; cfg_start = 1'b1;
        tick();
        cfg_wr = 1'b0; cfg_start = 1'b0;
        pll_lock = 1'b0;
        chk("wrstart_apply", dyn_idiv, 2);
        tick();
        chk("wrstart_idiv", {dyn_idiv, pll_rst}, {10'd5, 1'b1});
        measure_rst(1'b0, n);
        chk("wrstart_rst_len", n, 16);

        // Glitchy lock: 30 high, 5 low, then high
        repeat (10) tick();
        n_done = 0;
        pll_lock = 1'b1;
        repeat (30) begin tick(); n_done += int'(done); end
        pll_lock = 1'b0;
        repeat (5) begin tick(); n_done += int'(done); end
        chk("glitch_no_done", n_done, 0);
        pll_lock = 1'b1;
        wait_done(k);
        chk("glitch_done_latency", k, 67);

        // Lock loss while LOCKED
        tick();
        pll_lock = 1'b0;
        tick(); tick();
        chk("loss_early", lock_lost, 0);
        tick();
        chk("loss_pulse", {lock_lost, locked, busy, pll_rst}, 4'b1010);
        tick();
        chk("loss_pulse_end", lock_lost, 0);

        // Timeout counter restarts on lock loss
        wait_err(k);
        chk("loss_timeout", k, 999);
        chk("err_state", {err, pll_rst, busy, locked}, 4'b1100);

        // Restart from ERR, then full timeout from pll_rst release
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("err_cleared", {err, busy}, 2'b01);
        tick();
        measure_rst(1'b0, n);
        chk("err_rerun_rst_len", n, 16);
        wait_err(k);
        chk("timeout_exact", k, 1000);
        chk("timeout_pll_rst", {err, pll_rst}, 2'b11);

        // Recover to lock
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        tick();
        measure_rst(1'b0, n);
        repeat (20) tick();
        pll_lock = 1'b1;
        wait_done(k);
        chk("recover_locked", {locked, err, dyn_idiv}, {2'b10, 10'd5});

`ifdef PLL_CFG_READBACK_EN
        wr(5'd12, 13'h1ABC);
        cfg_rd = 1'b1; cfg_addr = 5'd12;
        tick();
        chk("rd_addr12", cfg_rdata, 13'h1ABC);
        cfg_addr = 5'd2;
        tick();
        chk("rd_addr2", cfg_rdata, 13'd200);
        cfg_addr = 5'd25;
        tick();
        chk("rd_addr25", cfg_rdata, 0);
        cfg_rd = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
